// File: rtl/fc_event_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fc_event_serializer
// Description : Collects single-cycle peripheral event pulses, buffers them in
//               per-source saturating pending counters and serializes them as
//               event IDs into the FC event FIFO push port. A round-robin
//               arbiter shares the port between sources.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               per_events_i           - one-cycle event pulses per source
//               event_fifo_valid_o     - ID presented to the FIFO
//               event_fifo_data_o      - presented ID (ID_OFFSET + source)
//               event_fifo_fulln_i     - FIFO not full (push = valid & fulln)
//               lost_event_o           - one-cycle pulse per dropped event
//               lost_cnt_o             - saturating dropped-event total (opt.)
//               lost_cnt_clr_i         - synchronous clear of lost_cnt_o (opt.)
// Options     : FC_EVT_LOST_CNT_EN - compiles in lost_cnt_o / lost_cnt_clr_i
//               and the 16-bit saturating lost-event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_event_serializer #(
    parameter int NB_EVENTS      = 32,
    parameter int EVENT_ID_WIDTH = 8,
    parameter int ID_OFFSET      = 0,
    parameter int PEND_CNT_WIDTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_EVENTS-1:0]      per_events_i,
    output logic                      event_fifo_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
    input  logic                      event_fifo_fulln_i,
    output logic [NB_EVENTS-1:0]      lost_event_o
`ifdef FC_EVT_LOST_CNT_EN
    ,
    output logic [15:0]               lost_cnt_o,
    input  logic                      lost_cnt_clr_i
`endif
);

    localparam int IDX_W = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;
    localparam logic [PEND_CNT_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_EVENTS - 1);

    // The pushed ID must never wrap inside EVENT_ID_WIDTH bits.
    if (longint'(ID_OFFSET) + longint'(NB_EVENTS) > (longint'(1) << EVENT_ID_WIDTH)) begin : g_id_range_check
        $error("fc_event_serializer: ID_OFFSET + NB_EVENTS exceeds 2**EVENT_ID_WIDTH");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [EVENT_ID_WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]            last_grant_q, last_grant_d;
    logic [PEND_CNT_WIDTH-1:0]   pend_q [NB_EVENTS];
    logic [PEND_CNT_WIDTH-1:0]   pend_d [NB_EVENTS];
    logic [NB_EVENTS-1:0]        lost_event_q, lost_event_d;

    logic                        can_load;
    logic [NB_EVENTS-1:0]        pend_nz;
    logic                        grant_found;
    logic [IDX_W-1:0]            grant_idx;
    logic [IDX_W-1:0]            cand_idx;
    logic [NB_EVENTS-1:0]        grant_vec;

    // The output register may take a new ID when empty or when its current
    // ID leaves this cycle; this is what allows one push per cycle.
    assign can_load = (state_q == ST_EMPTY) || event_fifo_fulln_i;

    // Round-robin: first non-empty source searching upward from last_grant+1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        grant_vec   = '0;
        for (int i = 0; i < NB_EVENTS; i++) begin
            pend_nz[i] = (pend_q[i] != '0);
        end
        if (can_load) begin
            for (int k = 1; k <= NB_EVENTS; k++) begin
                cand_idx = IDX_W'((int'(last_grant_q) + k) % NB_EVENTS);
                if (!grant_found && pend_nz[cand_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
        if (grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Pending counters: a pulse with no grant at the ceiling is dropped.
    always_comb begin
        lost_event_d = '0;
        for (int i = 0; i < NB_EVENTS; i++) begin
            pend_d[i] = pend_q[i];
            if (per_events_i[i] && !grant_vec[i]) begin
                if (pend_q[i] == PEND_MAX) begin
                    lost_event_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end else if (!per_events_i[i] && grant_vec[i]) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    // Output register: load on grant, drain to EMPTY when nothing follows,
    // otherwise hold (valid is never withdrawn while the FIFO is full).
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        if (grant_found) begin
            state_d      = ST_FULL;
            data_d       = EVENT_ID_WIDTH'(ID_OFFSET) + EVENT_ID_WIDTH'(grant_idx);
            last_grant_d = grant_idx;
        end else if (can_load) begin
            state_d      = ST_EMPTY;
        end
    end

`ifdef FC_EVT_LOST_CNT_EN
    localparam int DROP_W = $clog2(NB_EVENTS + 1);

    logic [15:0]       lost_cnt_q, lost_cnt_d;
    logic [DROP_W-1:0] drop_cnt;
    logic [16:0]       lost_sum;

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NB_EVENTS; i++) begin
            drop_cnt = drop_cnt + DROP_W'(lost_event_d[i]);
        end
        lost_sum = {1'b0, lost_cnt_q} + 17'(drop_cnt);
        if (lost_cnt_clr_i) begin
            lost_cnt_d = '0;
        end else if (lost_sum[16]) begin
            lost_cnt_d = 16'hFFFF;
        end else begin
            lost_cnt_d = lost_sum[15:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lost_cnt_q <= '0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign lost_cnt_o = lost_cnt_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_EMPTY;
            data_q       <= '0;
            last_grant_q <= LAST_IDX;
            lost_event_q <= '0;
            for (int i = 0; i < NB_EVENTS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            lost_event_q <= lost_event_d;
            for (int i = 0; i < NB_EVENTS; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign event_fifo_valid_o = (state_q == ST_FULL);
    assign event_fifo_data_o  = data_q;
    assign lost_event_o       = lost_event_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_event_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_event_serializer
// Description : Directed self-checking bench for fc_event_serializer with
//               default parameters. Pushes are recorded into a queue and
//               compared against hand-computed ID sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_event_serializer;

    logic        clk;
    logic        rst_n;
    logic [31:0] per_events;
    logic        valid;
    logic [7:0]  data;
    logic        fulln;
    logic [31:0] lost_event;
`ifdef FC_EVT_LOST_CNT_EN
    logic [15:0] lost_cnt;
    logic        lost_cnt_clr;
`endif

    int n_checks;
    int n_errors;
    logic [7:0] push_q [$];

    fc_event_serializer #(
        .NB_EVENTS      (32),
        .EVENT_ID_WIDTH (8),
        .ID_OFFSET      (0),
        .PEND_CNT_WIDTH (2)
    ) u_dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .per_events_i       (per_events),
        .event_fifo_valid_o (valid),
        .event_fifo_data_o  (data),
        .event_fifo_fulln_i (fulln),
        .lost_event_o       (lost_event)
`ifdef FC_EVT_LOST_CNT_EN
        ,
        .lost_cnt_o         (lost_cnt),
        .lost_cnt_clr_i     (lost_cnt_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A push happens on the next rising edge whenever valid & fulln here.
    always @(negedge clk) begin
        if (rst_n && valid && fulln) begin
            push_q.push_back(data);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        per_events = '0;
        repeat (2) tick();
        rst_n      = 1'b1;
        push_q.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        per_events = '0;
        fulln      = 1'b1;
`ifdef FC_EVT_LOST_CNT_EN
        lost_cnt_clr = 1'b0;
`endif
        do_reset();

        // Reset values
        check_value("rst_valid", 32'(valid), 32'd0);
        check_value("rst_data", 32'(data), 32'd0);
        check_value("rst_lost", lost_event, 32'd0);
`ifdef FC_EVT_LOST_CNT_EN
        check_value("rst_lost_cnt", 32'(lost_cnt), 32'd0);
`endif

        // Single pulse on source 5: two-cycle latency, one cycle valid
        per_events = 32'h1 << 5;
        tick();
        per_events = '0;
        check_value("s5_lat1_valid", 32'(valid), 32'd0);
        tick();
        check_value("s5_valid", 32'(valid), 32'd1);
        check_value("s5_data", 32'(data), 32'd5);
        tick();
        check_value("s5_drain_valid", 32'(valid), 32'd0);
        check_value("s5_push_count", 32'(push_q.size()), 32'd1);

        // Sources 3, 7, 20 together: back-to-back in round-robin order
        do_reset();
        per_events = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 20);
        tick();
        per_events = '0;
        tick();
        check_value("b2b_id0", 32'(data), 32'd3);
        tick();
        check_value("b2b_id1", 32'(data), 32'd7);
        check_value("b2b_v1", 32'(valid), 32'd1);
        tick();
        check_value("b2b_id2", 32'(data), 32'd20);
        check_value("b2b_v2", 32'(valid), 32'd1);
        tick();
        check_value("b2b_drain", 32'(valid), 32'd0);
        check_value("b2b_count", 32'(push_q.size()), 32'd3);

        // Source 9 held by a full FIFO for 10 cycles
        do_reset();
        fulln      = 1'b0;
        per_events = 32'h1 << 9;
        tick();
        per_events = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            check_value("hold_valid", 32'(valid), 32'd1);
            check_value("hold_data", 32'(data), 32'd9);
            if (c < 9) tick();
        end
        fulln = 1'b1;
        tick();
        check_value("hold_release", 32'(valid), 32'd0);
        check_value("hold_count", 32'(push_q.size()), 32'd1);
        if (push_q.size() > 0) check_value("hold_push_id", 32'(push_q[0]), 32'd9);

        // Saturation: five pulses on source 2 with the FIFO full
        do_reset();
        fulln      = 1'b0;
        per_events = 32'h1 << 2;
        repeat (4) tick();
        check_value("sat_no_loss_yet", lost_event, 32'd0);
        tick();
        per_events = '0;
        check_value("sat_lost_pulse", lost_event, 32'h4);
`ifdef FC_EVT_LOST_CNT_EN
        check_value("sat_lost_cnt", 32'(lost_cnt), 32'd1);
`endif
        tick();
        check_value("sat_lost_clear", lost_event, 32'd0);
        fulln = 1'b1;
        repeat (8) tick();
        check_value("sat_push_count", 32'(push_q.size()), 32'd4);
        foreach (push_q[i]) check_value("sat_push_id", 32'(push_q[i]), 32'd2);
        check_value("sat_drained", 32'(valid), 32'd0);
`ifdef FC_EVT_LOST_CNT_EN
        lost_cnt_clr = 1'b1;
        tick();
        lost_cnt_clr = 1'b0;
        check_value("lost_cnt_clr", 32'(lost_cnt), 32'd0);
`endif

        // Fairness: source 0 pulsing every cycle must not starve source 1
        do_reset();
        fulln      = 1'b1;
        per_events = 32'h3;
        tick();
        per_events = 32'h1;
        repeat (5) tick();
        per_events = '0;
        repeat (4) tick();
        check_value("rr_count_min", 32'(push_q.size() >= 3), 32'd1);
        if (push_q.size() >= 3) begin
            check_value("rr_push0", 32'(push_q[0]), 32'd0);
            check_value("rr_push1", 32'(push_q[1]), 32'd1);
            check_value("rr_push2", 32'(push_q[2]), 32'd0);
        end

        // Asynchronous reset mid-stream discards everything in flight
        do_reset();
        fulln      = 1'b0;
        per_events = (32'h1 << 1) | (32'h1 << 4) | (32'h1 << 8) | (32'h1 << 12);
        tick();
        per_events = '0;
        tick();
        check_value("ar_valid_before", 32'(valid), 32'd1);
        check_value("ar_data_before", 32'(data), 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("ar_valid_async", 32'(valid), 32'd0);
        tick();
        rst_n = 1'b1;
        fulln = 1'b1;
        push_q.delete();
        repeat (3) tick();
        check_value("ar_no_stale_valid", 32'(valid), 32'd0);
        check_value("ar_no_stale_push", 32'(push_q.size()), 32'd0);
        per_events = 32'h1;
        tick();
        per_events = '0;
        check_value("ar_new_lat1", 32'(valid), 32'd0);
        tick();
        check_value("ar_new_valid", 32'(valid), 32'd1);
        check_value("ar_new_data", 32'(data), 32'd0);
        tick();
        check_value("ar_new_count", 32'(push_q.size()), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
